// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/write-back controller for the
// 16-bit datapath. It sits directly upstream of the register bank.
//
// Each instruction moves through FETCH -> DECODE -> EXEC -> WB. That is four
// cycles with zero-wait memory, plus one cycle for every FETCH wait cycle.
//
// Ports:
//   clock, reset   clock; asynchronous active-high reset
//   instr_req      instruction request (high in FETCH while reset is low)
//   instr_valid    instr_data is valid this cycle (ignored outside FETCH)
//   instr_data     fetched instruction
//   pc             current instruction address
//   a_zero         register bank output A equals zero (used by BEQZ)
//   sel_sa/sb/sc   register bank read A / read B / write addresses
//   hab_escrita    register bank write enable, one-cycle pulse in WB
//   alu_op         0=PASS_B 1=ADD 2=SUB 3=AND 4=OR
//   sel_imm        selects imm instead of the ALU result as the write value
//   imm            zero-extended IR[7:0]
//   halted         core stopped; only reset restarts it
//   illegal        sticky flag: an undefined opcode was decoded
//   fetch_timeout  (CU_WATCHDOG_EN only) FETCH waited TIMEOUT cycles without
//                  valid data; sticky until reset
//
// Optional feature macro: CU_WATCHDOG_EN (fetch watchdog).
module control_unit #(
  parameter int BITS_PALAVRA  = 16,
  parameter int END_REGISTROS = 2,
  parameter int PC_W          = 8,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     instr_req,
  input  logic                     instr_valid,
  input  logic [BITS_PALAVRA-1:0]  instr_data,
  output logic [PC_W-1:0]          pc,
  input  logic                     a_zero,
  output logic [END_REGISTROS-1:0] sel_sa,
  output logic [END_REGISTROS-1:0] sel_sb,
  output logic [END_REGISTROS-1:0] sel_sc,
  output logic                     hab_escrita,
  output logic [2:0]               alu_op,
  output logic                     sel_imm,
  output logic [BITS_PALAVRA-1:0]  imm,
`ifdef CU_WATCHDOG_EN
  output logic                     fetch_timeout,
`endif
  output logic                     halted,
  output logic                     illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t                     state_q;
  logic [PC_W-1:0]            pc_q, next_pc_q, next_pc_d;
  logic [BITS_PALAVRA-1:0]    ir_q;
  logic [END_REGISTROS-1:0]   sel_sa_q, sel_sb_q, sel_sc_q;
  logic [2:0]                 alu_op_q;
  logic                       sel_imm_q, hab_escrita_q, halted_q, illegal_q;
  logic [BITS_PALAVRA-1:0]    imm_q;
  logic [3:0]                 op_ir, op_in;
  logic [PC_W-1:0]            target;

`ifdef CU_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]            wd_q;
  logic                       fetch_timeout_q;
  assign fetch_timeout = fetch_timeout_q;
`endif

  assign op_ir  = ir_q[15:12];
  assign op_in  = instr_data[15:12];
  // Branch target: imm8 zero-extended or truncated to the PC width.
  assign target = PC_W'(ir_q[7:0]);

  // Resolved in EXEC; a_zero is only meaningful for BEQZ.
  always_comb begin
    next_pc_d = pc_q + 1'b1;
    if (op_ir == 4'h6 || (op_ir == 4'h7 && a_zero)) next_pc_d = target;
  end

  // Combinational so the request drops the instant reset rises.
  assign instr_req   = (state_q == S_FETCH) && !reset;
  assign pc          = pc_q;
  assign sel_sa      = sel_sa_q;
  assign sel_sb      = sel_sb_q;
  assign sel_sc      = sel_sc_q;
  assign alu_op      = alu_op_q;
  assign sel_imm     = sel_imm_q;
  assign imm         = imm_q;
  assign hab_escrita = hab_escrita_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      next_pc_q     <= '0;
      ir_q          <= '0;
      sel_sa_q      <= '0;
      sel_sb_q      <= '0;
      sel_sc_q      <= '0;
      alu_op_q      <= '0;
      sel_imm_q     <= 1'b0;
      imm_q         <= '0;
      hab_escrita_q <= 1'b0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef CU_WATCHDOG_EN
      wd_q            <= '0;
      fetch_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            // Decode fields are latched with the instruction, so they are
            // stable from DECODE through WB.
            ir_q      <= instr_data;
            sel_sa_q  <= END_REGISTROS'(instr_data[9:8]);
            sel_sb_q  <= END_REGISTROS'(instr_data[7:6]);
            sel_sc_q  <= END_REGISTROS'(instr_data[11:10]);
            imm_q     <= BITS_PALAVRA'(instr_data[7:0]);
            sel_imm_q <= (op_in == 4'h5);
            alu_op_q  <= (op_in >= 4'h1 && op_in <= 4'h4) ? op_in[2:0] : 3'd0;
            state_q   <= S_DECODE;
`ifdef CU_WATCHDOG_EN
            wd_q      <= '0;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_q            <= '0;
            fetch_timeout_q <= 1'b1;
            halted_q        <= 1'b1;
            state_q         <= S_HALT;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        S_DECODE: begin
          if (op_ir >= 4'h8 && op_ir <= 4'hE) illegal_q <= 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op_ir == 4'hF) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            next_pc_q     <= next_pc_d;
            hab_escrita_q <= (op_ir >= 4'h1 && op_ir <= 4'h5);
            state_q       <= S_WB;
          end
        end
        S_WB: begin
          pc_q          <= next_pc_q;
          hab_escrita_q <= 1'b0;
          state_q       <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_req;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [7:0]  pc;
  logic        a_zero;
  logic [1:0]  sel_sa, sel_sb, sel_sc;
  logic        hab_escrita;
  logic [2:0]  alu_op;
  logic        sel_imm;
  logic [15:0] imm;
  logic        halted;
  logic        illegal;
`ifdef CU_WATCHDOG_EN
  logic        fetch_timeout;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int hab_pulses  = 0;
  int base;

  control_unit dut (
    .clock(clock), .reset(reset), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr_data(instr_data), .pc(pc),
    .a_zero(a_zero), .sel_sa(sel_sa), .sel_sb(sel_sb), .sel_sc(sel_sc),
    .hab_escrita(hab_escrita), .alu_op(alu_op), .sel_imm(sel_imm),
    .imm(imm),
`ifdef CU_WATCHDOG_EN
    .fetch_timeout(fetch_timeout),
`endif
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (hab_escrita) hab_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction in FETCH and advance to WB (3 edges).
  task automatic to_wb(input logic [15:0] d, input logic az);
    instr_data  = d;
    a_zero      = az;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  instr_req, 0);
    check({tag, "_pc"},   pc, 0);
    check({tag, "_hab"},  hab_escrita, 0);
    check({tag, "_halt"}, halted, 0);
    check({tag, "_ill"},  illegal, 0);
    check({tag, "_sel"},  {sel_sa, sel_sb, sel_sc, alu_op, sel_imm}, 0);
    check({tag, "_imm"},  imm, 0);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_data = 16'h0; a_zero = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    #1;
    check("fetch_req", instr_req, 1);

    // LDI r1,5
    base = hab_pulses;
    instr_data = 16'h5405; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("ldi_sc", sel_sc, 1);
    check("ldi_selimm", sel_imm, 1);
    check("ldi_imm", imm, 16'h0005);
    check("ldi_nohab_dec", hab_escrita, 0);
    tick();
    check("ldi_nohab_exec", hab_escrita, 0);
    tick();
    check("ldi_hab_c4", hab_escrita, 1);
    check("ldi_pc_wb", pc, 0);
    tick();
    check("ldi_hab_off", hab_escrita, 0);
    check("ldi_pc", pc, 1);
    check("ldi_pulses", hab_pulses - base, 1);

    // ADD r3,r2,r1
    base = hab_pulses;
    to_wb(16'h1E40, 1'b0);
    check("add_op", alu_op, 1);
    check("add_sa", sel_sa, 2);
    check("add_sb", sel_sb, 1);
    check("add_sc", sel_sc, 3);
    check("add_selimm", sel_imm, 0);
    check("add_hab", hab_escrita, 1);
    tick();
    check("add_pc", pc, 2);
    check("add_pulses", hab_pulses - base, 1);

    // BEQZ taken, then not taken
    base = hab_pulses;
    to_wb(16'h7020, 1'b1);
    check("beqz_t_hab", hab_escrita, 0);
    tick();
    check("beqz_t_pc", pc, 8'h20);
    to_wb(16'h7020, 1'b0);
    tick();
    check("beqz_n_pc", pc, 8'h21);
    check("beqz_pulses", hab_pulses - base, 0);

    // FETCH wait: 3 cycles without valid
    tick(); tick(); tick();
    check("wait_req", instr_req, 1);
    check("wait_pc", pc, 8'h21);

    // JMP 0xFF, then NOP wraps pc
    to_wb(16'h60FF, 1'b0);
    tick();
    check("jmp_pc", pc, 8'hFF);
    to_wb(16'h0000, 1'b0);
    check("nop_hab", hab_escrita, 0);
    tick();
    check("wrap_pc", pc, 8'h00);

    // Illegal opcode
    base = hab_pulses;
    to_wb(16'h9123, 1'b0);
    check("ill_flag", illegal, 1);
    check("ill_hab", hab_escrita, 0);
    tick();
    check("ill_pc", pc, 1);
    check("ill_pulses", hab_pulses - base, 0);

    // HALT
    to_wb(16'hF000, 1'b0);
    check("halt_halted", halted, 1);
    check("halt_req", instr_req, 0);
    instr_data = 16'h5405; instr_valid = 1'b1;
    tick(); tick(); tick(); tick();
    instr_valid = 1'b0;
    check("halt_pc", pc, 1);
    check("halt_stay", halted, 1);
    check("halt_ill_sticky", illegal, 1);
    check("halt_hab", hab_escrita, 0);
    reset = 1'b1;
    #1;
    check_all_zero("halt_rst");
    tick();
    reset = 1'b0;

    // Reset while in WB
    to_wb(16'h5405, 1'b0);
    check("wbrst_hab_pre", hab_escrita, 1);
    reset = 1'b1;
    #1;
    check("wbrst_hab", hab_escrita, 0);
    check("wbrst_pc", pc, 0);
    base = hab_pulses;
    tick();
    reset = 1'b0;
    tick();
    check("wbrst_pulses", hab_pulses - base, 0);
    check("wbrst_req", instr_req, 1);

`ifdef CU_WATCHDOG_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("wd_not_yet", halted, 0);
    tick();
    check("wd_timeout", fetch_timeout, 1);
    check("wd_halted", halted, 1);
    check("wd_req", instr_req, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
